// File: rtl/yuv422_scanout.sv
// YUV 4:2:2 frame-buffer scan-out: raster timing, read addressing and latency-aligned HDMI-side outputs.
// Optional colour-bar generator enabled by defining YUV422_SCANOUT_PATTERN_EN.
module yuv422_scanout #(
    parameter int   H_ACTIVE   = 1280,
    parameter int   H_FP       = 110,
    parameter int   H_SYNC     = 40,
    parameter int   H_BP       = 220,
    parameter int   V_ACTIVE   = 720,
    parameter int   V_FP       = 5,
    parameter int   V_SYNC     = 5,
    parameter int   V_BP       = 20,
    parameter logic SYNC_POL   = 1'b1,
    parameter int   RD_LATENCY = 1,
    parameter int   ADR_BITS   = $clog2(H_ACTIVE * V_ACTIVE)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
`ifdef YUV422_SCANOUT_PATTERN_EN
    input  logic                pattern_i,
`endif
    output logic [ADR_BITS-1:0] rd_addr_o,
    input  logic [15:0]         rd_d_i,
    output logic                hsync_o,
    output logic                vsync_o,
    output logic                de_o,
    output logic [15:0]         pix_o,
    output logic                frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0]       H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0]       H_SS     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]       H_SE     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0]       H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]       V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0]       V_SS     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]       V_SE     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0]       V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [ADR_BITS-1:0] ADR_LAST = ADR_BITS'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_cnt, h_d;
    logic [VW-1:0] v_cnt, v_d;
    logic          act_d, fs_d;
    logic          de_p0, hs_p0, vs_p0, fs_p0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            h_cnt     <= '0;
            v_cnt     <= '0;
            rd_addr_o <= '0;
        end else begin
            state_q <= state_d;
            h_cnt   <= h_d;
            v_cnt   <= v_d;
            // Address for the upcoming pixel is registered so it is valid during that pixel's cycle.
            if (act_d)
                rd_addr_o <= (fs_d || rd_addr_o == ADR_LAST) ? '0 : rd_addr_o + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_cnt;
        v_d     = v_cnt;
        case (state_q)
            IDLE: begin
                h_d = '0;
                v_d = '0;
                if (en_i)
                    state_d = RUN;
            end
            RUN: begin
                if (h_cnt == H_LAST) begin
                    h_d = '0;
                    if (v_cnt == V_LAST) begin
                        v_d = '0;
                        if (!en_i)
                            state_d = IDLE;
                    end else begin
                        v_d = v_cnt + 1'b1;
                    end
                end else begin
                    h_d = h_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        act_d = (state_d == RUN) && (h_d < H_ACT_C) && (v_d < V_ACT_C);
        fs_d  = act_d && (h_d == '0) && (v_d == '0);

        de_p0 = (state_q == RUN) && (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        hs_p0 = (state_q == RUN) && (h_cnt >= H_SS) && (h_cnt < H_SE);
        vs_p0 = (state_q == RUN) && (v_cnt >= V_SS) && (v_cnt < V_SE);
        fs_p0 = de_p0 && (h_cnt == '0) && (v_cnt == '0);
    end

    // Stage p1..pL: control delay matching the frame-buffer read latency.
    logic [3:0] ctl_p1 [RD_LATENCY];
    logic [3:0] ctl_pl;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RD_LATENCY; i++)
                ctl_p1[i] <= '0;
        end else begin
            ctl_p1[0] <= {fs_p0, vs_p0, hs_p0, de_p0};
            for (int i = 1; i < RD_LATENCY; i++)
                ctl_p1[i] <= ctl_p1[i-1];
        end
    end

    assign ctl_pl = ctl_p1[RD_LATENCY-1];

    logic [15:0] pix_src;

`ifdef YUV422_SCANOUT_PATTERN_EN
    localparam logic [HW-1:0] BAR_W = HW'(H_ACTIVE / 8);

    function automatic logic [15:0] bar_rom(input logic [2:0] bar, input logic odd);
        logic [7:0] y, cb, cr;
        case (bar)
            3'd0:    begin y = 8'd180; cb = 8'd128; cr = 8'd128; end
            3'd1:    begin y = 8'd162; cb = 8'd44;  cr = 8'd142; end
            3'd2:    begin y = 8'd131; cb = 8'd156; cr = 8'd44;  end
            3'd3:    begin y = 8'd112; cb = 8'd72;  cr = 8'd58;  end
            3'd4:    begin y = 8'd84;  cb = 8'd184; cr = 8'd198; end
            3'd5:    begin y = 8'd65;  cb = 8'd100; cr = 8'd212; end
            3'd6:    begin y = 8'd35;  cb = 8'd212; cr = 8'd114; end
            default: begin y = 8'd16;  cb = 8'd128; cr = 8'd128; end
        endcase
        return {odd ? cb : cr, y};
    endfunction

    logic [HW-1:0] bar_full;
    logic [3:0]    pat_p1 [RD_LATENCY];

    assign bar_full = h_cnt / BAR_W;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RD_LATENCY; i++)
                pat_p1[i] <= '0;
        end else begin
            pat_p1[0] <= {bar_full[2:0], h_cnt[0]};
            for (int i = 1; i < RD_LATENCY; i++)
                pat_p1[i] <= pat_p1[i-1];
        end
    end

    assign pix_src = pattern_i ? bar_rom(pat_p1[RD_LATENCY-1][3:1], pat_p1[RD_LATENCY-1][0])
                               : rd_d_i;
`else
    assign pix_src = rd_d_i;
`endif

    // Output register: all five outputs update on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            de_o          <= 1'b0;
            hsync_o       <= ~SYNC_POL;
            vsync_o       <= ~SYNC_POL;
            frame_start_o <= 1'b0;
            pix_o         <= '0;
        end else begin
            de_o          <= ctl_pl[0];
            hsync_o       <= ctl_pl[1] ? SYNC_POL : ~SYNC_POL;
            vsync_o       <= ctl_pl[2] ? SYNC_POL : ~SYNC_POL;
            frame_start_o <= ctl_pl[3];
            pix_o         <= ctl_pl[0] ? pix_src : 16'h0000;
        end
    end

endmodule

// File: tb/tb_yuv422_scanout.sv
// Directed bench for yuv422_scanout on an 8x4 raster (14x7 total), RD_LATENCY=1 and RD_LATENCY=3 instances.
module tb_yuv422_scanout;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [4:0] rd_addr_a, rd_addr_b;
    logic [15:0] rd_d_a, rd_d_b, pix_a, pix_b;
    logic       hsync_a, vsync_a, de_a, fs_a;
    logic       hsync_b, vsync_b, de_b, fs_b;
    logic [15:0] fb_b1, fb_b2;

    int k      = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    yuv422_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .RD_LATENCY(1)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(en),
`ifdef YUV422_SCANOUT_PATTERN_EN
        .pattern_i(1'b0),
`endif
        .rd_addr_o(rd_addr_a), .rd_d_i(rd_d_a),
        .hsync_o(hsync_a), .vsync_o(vsync_a), .de_o(de_a),
        .pix_o(pix_a), .frame_start_o(fs_a)
    );

    yuv422_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .RD_LATENCY(3)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(en),
`ifdef YUV422_SCANOUT_PATTERN_EN
        .pattern_i(1'b0),
`endif
        .rd_addr_o(rd_addr_b), .rd_d_i(rd_d_b),
        .hsync_o(hsync_b), .vsync_o(vsync_b), .de_o(de_b),
        .pix_o(pix_b), .frame_start_o(fs_b)
    );

    function automatic logic [15:0] fb_word(input logic [4:0] a);
        logic [7:0] a8;
        a8 = {3'b000, a};
        return {a8, ~a8};
    endfunction

    // Frame-buffer models with 1- and 3-cycle read latency.
    always @(posedge clk) begin
        rd_d_a <= fb_word(rd_addr_a);
        fb_b1  <= fb_word(rd_addr_b);
        fb_b2  <= fb_b1;
        rd_d_b <= fb_b2;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic goto(input int target);
        while (k < target) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr", 32'(rd_addr_a), 32'd0);
        check("rst_hs",   32'(hsync_a),   32'd0);
        check("rst_vs",   32'(vsync_a),   32'd0);
        check("rst_de",   32'(de_a),      32'd0);
        check("rst_pix",  32'(pix_a),     32'd0);
        check("rst_fs",   32'(fs_a),      32'd0);
        check("rst_b_de", 32'(de_b),      32'd0);

        rst = 1'b0;
        en  = 1'b1;
        goto(1);   check("first_addr", 32'(rd_addr_a), 32'd0);
                   check("first_de",   32'(de_a),      32'd0);
        goto(3);   check("de_rise",    32'(de_a),      32'd1);
                   check("pix0",       32'(pix_a),     32'h00FF);
                   check("fs0",        32'(fs_a),      32'd1);
                   check("addr_k3",    32'(rd_addr_a), 32'd2);
                   check("b_de_early", 32'(de_b),      32'd0);
        goto(4);   check("pix1",       32'(pix_a),     32'h01FE);
                   check("fs_once",    32'(fs_a),      32'd0);
        goto(5);   check("b_de_rise",  32'(de_b),      32'd1);
                   check("b_pix0",     32'(pix_b),     32'h00FF);
                   check("b_fs0",      32'(fs_b),      32'd1);
        goto(9);   check("addr_hold",  32'(rd_addr_a), 32'd7);
        goto(10);  check("pix7",       32'(pix_a),     32'h07F8);
                   check("de_last",    32'(de_a),      32'd1);
        goto(11);  check("de_fall",    32'(de_a),      32'd0);
                   check("pix_blank",  32'(pix_a),     32'd0);
        goto(12);  check("hs_pre",     32'(hsync_a),   32'd0);
                   check("b_pix7",     32'(pix_b),     32'h07F8);
        goto(13);  check("hs_on",      32'(hsync_a),   32'd1);
                   check("b_de_fall",  32'(de_b),      32'd0);
                   check("b_pix_blank",32'(pix_b),     32'd0);
        goto(14);  check("hs_on2",     32'(hsync_a),   32'd1);
        goto(15);  check("hs_off",     32'(hsync_a),   32'd0);
                   check("addr_line1", 32'(rd_addr_a), 32'd8);
                   check("b_hs_on",    32'(hsync_b),   32'd1);
        goto(16);  check("de_gap",     32'(de_a),      32'd0);
        goto(17);  check("de_line1",   32'(de_a),      32'd1);
                   check("pix8",       32'(pix_a),     32'h08F7);
        goto(50);  check("addr_last",  32'(rd_addr_a), 32'd31);
        goto(52);  check("pix31",      32'(pix_a),     32'h1FE0);
                   check("fs_mid",     32'(fs_a),      32'd0);
        goto(53);  check("de_after31", 32'(de_a),      32'd0);
        goto(72);  check("vs_pre",     32'(vsync_a),   32'd0);
        goto(73);  check("vs_on",      32'(vsync_a),   32'd1);
        goto(86);  check("vs_on_end",  32'(vsync_a),   32'd1);
        goto(87);  check("vs_off",     32'(vsync_a),   32'd0);
        goto(99);  check("addr_wrap",  32'(rd_addr_a), 32'd0);
        goto(101); check("fs_frame2",  32'(fs_a),      32'd1);
                   check("pix0_f2",    32'(pix_a),     32'h00FF);
        goto(102); check("fs_f2_once", 32'(fs_a),      32'd0);

        goto(110);
        en = 1'b0;
        goto(148); check("drop_addr31", 32'(rd_addr_a), 32'd31);
        goto(150); check("drop_pix31",  32'(pix_a),     32'h1FE0);
                   check("drop_de",     32'(de_a),      32'd1);
        goto(152); check("drop_b_pix31",32'(pix_b),     32'h1FE0);
        goto(171); check("drop_vs",     32'(vsync_a),   32'd1);
        goto(199); check("idle_de",     32'(de_a),      32'd0);
                   check("idle_hs",     32'(hsync_a),   32'd0);
                   check("idle_vs",     32'(vsync_a),   32'd0);
                   check("idle_pix",    32'(pix_a),     32'd0);
                   check("idle_addr",   32'(rd_addr_a), 32'd31);
        goto(205); check("idle_de2",    32'(de_a),      32'd0);
                   check("idle_fs",     32'(fs_a),      32'd0);

        en = 1'b1;
        goto(206); check("restart_addr", 32'(rd_addr_a), 32'd0);
        goto(208); check("restart_fs",   32'(fs_a),      32'd1);
                   check("restart_pix",  32'(pix_a),     32'h00FF);
        goto(209); check("restart_addr3",32'(rd_addr_a), 32'd3);

        goto(212);
        rst = 1'b1;
        goto(213); check("mrst_addr", 32'(rd_addr_a), 32'd0);
                   check("mrst_de",   32'(de_a),      32'd0);
                   check("mrst_pix",  32'(pix_a),     32'd0);
                   check("mrst_hs",   32'(hsync_a),   32'd0);
                   check("mrst_vs",   32'(vsync_a),   32'd0);
                   check("mrst_fs",   32'(fs_a),      32'd0);
                   check("mrst_b_de", 32'(de_b),      32'd0);
                   check("mrst_b_pix",32'(pix_b),     32'd0);
        rst = 1'b0;
        goto(214); check("post_rst_addr", 32'(rd_addr_a), 32'd0);
                   check("post_rst_de",   32'(de_a),      32'd0);
        goto(216); check("post_rst_pix",  32'(pix_a),     32'h00FF);
                   check("post_rst_fs",   32'(fs_a),      32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/yuv422_scanout.md
# yuv422_scanout

Video scan-out stage that reads the YUV 4:2:2 frame buffer and drives the HDMI transmitter side. It generates raster timing from parameterised counters and issues one frame-buffer read address per active pixel. It absorbs the buffer's read latency, so sync, data-enable and the 16-bit {chroma, Y} pixel leave the block mutually aligned.

## Interface
- H_ACTIVE, 1280, active pixels per line (even)
- H_FP / H_SYNC / H_BP, 110 / 40 / 220, horizontal porch and sync widths in pixels
- V_ACTIVE, 720, active lines per frame
- V_FP / V_SYNC / V_BP, 5 / 5 / 20, vertical porch and sync widths in lines
- SYNC_POL, 1, asserted level of hsync_o/vsync_o
- RD_LATENCY, 1, frame-buffer read latency in cycles (≥1)
- ADR_BITS, $clog2(H_ACTIVE*V_ACTIVE), frame-buffer address width
- clk_i  in  1  pixel clock
- rst_i  in  1  synchronous, active-high reset
- en_i  in  1  scan-out enable
- rd_addr_o  out  ADR_BITS  frame-buffer read address
- rd_d_i  in  16  frame-buffer read data {chroma[15:8], Y[7:0]}, valid RD_LATENCY cycles after its address
- hsync_o  out  1  horizontal sync
- vsync_o  out  1  vertical sync
- de_o  out  1  data enable
- pix_o  out  16  {chroma, Y}; even pixel carries Cr, odd pixel carries Cb
- frame_start_o  out  1  one-cycle pulse with the first active pixel of each frame

## Operation
- Raster order per line: active, FP, sync, BP. H_TOTAL = sum of H params; V_TOTAL = sum of V params.
- h_cnt runs 0..H_TOTAL-1. v_cnt advances when h_cnt wraps and runs 0..V_TOTAL-1.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- hsync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vsync asserted for whole lines with v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Address counter:
  - Increments by 1 on every active pixel.
  - Clears to 0 when the last active pixel (address H_ACTIVE*V_ACTIVE-1) is issued.
  - Also clears at every frame start.
  - It is a running counter, not a multiplier.
- rd_addr_o holds its last value outside the active region.
- States:
  - IDLE: counters at 0, outputs at reset values. Moves to RUN when en_i=1.
  - RUN: free-running raster. If en_i=0 is sampled on the last cycle of a frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1), go to IDLE; otherwise stay in RUN. Deasserting en_i mid-frame therefore finishes the current frame cleanly.
- Pipeline alignment:
  - hsync, vsync, de and frame_start pass through RD_LATENCY delay stages, then one output register.
  - pix_o registers rd_d_i.
  - All five outputs change on the same edge.
- pix_o is forced to 0 when the delayed de is 0.
- Chroma selection is done by the frame buffer from rd_addr_o[0]. This block passes rd_d_i through unmodified.
- Reset:
  - rst_i=1 at any cycle, including mid-frame, forces IDLE and clears all counters and delay stages.
  - Reset values: rd_addr_o=0, hsync_o=vsync_o=~SYNC_POL, de_o=0, pix_o=0, frame_start_o=0.

## Timing
- Address-to-output latency is RD_LATENCY+1 cycles. The address issued at cycle t has its pixel on pix_o, with de_o=1, at t+RD_LATENCY+1.
- The first address of a frame is issued on the first RUN cycle after en_i is seen high in IDLE.
- frame_start_o is high for exactly one cycle per frame, coincident with the first de_o=1 of the frame.
- de_o is high for exactly H_ACTIVE consecutive cycles per active line and for H_ACTIVE*V_ACTIVE cycles per frame.
- Line period is H_TOTAL cycles; frame period is H_TOTAL*V_TOTAL cycles.

## Configuration
- YUV422_SCANOUT_PATTERN_EN defined:
  - Adds input port pattern_i (1 bit).
  - While pattern_i=1, pix_o is replaced by 8 vertical colour bars, each H_ACTIVE/8 pixels wide, sourced from an internal YCbCr ROM. The same Cr/Cb even/odd alternation applies.
  - Timing and rd_addr_o are unchanged.
- Not defined: the port and generator are absent, and pix_o is always frame-buffer data.

## Test plan
- Small raster: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, RD_LATENCY=1, en_i=1 after reset.
  - Required: de_o bursts of 8 with period 14; hsync_o high for 2 cycles starting 2 cycles after each burst ends; frame period 98 cycles.
- Frame-buffer model returning {addr[7:0], ~addr[7:0]}:
  - Required: pix_o sequence 0x00FF, 0x01FE, … 0x1FE0 per frame.
  - Required: each value appears exactly 2 cycles after its address on rd_addr_o.
- Address wrap:
  - Required: after 31, rd_addr_o restarts at 0 in the next frame.
  - Required: frame_start_o pulses once per frame, aligned with pix_o=0x00FF.
- RD_LATENCY=3:
  - Required: same output waveforms as the first scenario, shifted 2 cycles later relative to rd_addr_o.
  - Required: no de/pix misalignment.
- en_i dropped mid-frame:
  - Required: the remaining active pixels of that frame are emitted.
  - Required: then IDLE with syncs inactive and de_o=0.
  - Required: re-asserting en_i restarts at address 0.
- rst_i pulsed mid-line:
  - Required: the next cycle shows all outputs at reset values and rd_addr_o=0.
  - With the macro defined, pattern_i=1 gives bar 0 values on the first 1 pixel, and the same for each bar thereafter.
